// File: rtl/polylut_arbiter_if.sv
// polylut_arbiter_if
// Groups the requester, polylut and response signals of one shared polylut
// arbiter into a single bundle.
//   slave  : the arbiter (consumes requests and lut_M2, drives grants, the lut
//            address, responses and status)
//   master : the surrounding environment (the requesters plus the polylut
//            instance that returns lut_M2)
// Signals:
//   req_valid   [NREQ]     per-requester request valid
//   req_addr    [NREQ*AW]  requester i address at bits [i*AW +: AW]
//   req_ready   [NREQ]     one-hot grant
//   hold                   suspends new grants
//   lut_address [AW]       address driven to the polylut
//   lut_M2      [OW]       polylut result
//   rsp_valid   [NREQ]     one-hot owner of rsp_data
//   rsp_data    [OW]       returned result
//   busy                   any transaction in flight
//   grant_count [16]       total accepted requests, wrapping
interface polylut_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 64,
    parameter int OW   = 20
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ready;
    logic               hold;
    logic [AW-1:0]      lut_address;
    logic [OW-1:0]      lut_M2;
    logic [NREQ-1:0]    rsp_valid;
    logic [OW-1:0]      rsp_data;
    logic               busy;
    logic [15:0]        grant_count;

    modport master (
        output req_valid, req_addr, hold, lut_M2,
        input  req_ready, lut_address, rsp_valid, rsp_data, busy, grant_count
    );

    modport slave (
        input  req_valid, req_addr, hold, lut_M2,
        output req_ready, lut_address, rsp_valid, rsp_data, busy, grant_count
    );
endinterface

// File: rtl/polylut_arbiter.sv
// polylut_arbiter
// Round-robin arbiter sharing one fixed-latency polylut instance among NREQ
// requesters. One request is granted per cycle; the winner's address goes
// straight to the polylut, and a {valid, one-hot tag} token travels down a
// LAT-deep pipeline so the result returning LAT cycles later is labelled with
// its owner. There is no response backpressure.
// Ports:
//   clk  : single rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : polylut_arbiter_if slave modport (requests, grant, lut address,
//          lut result, response, busy, grant_count)
// Parameters: NREQ requesters, AW address width, OW result width,
//             LAT address-to-result latency in cycles (1..8).
module polylut_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 64,
    parameter int OW   = 20,
    parameter int LAT  = 2
) (
    input  logic             clk,
    input  logic             rst,
    polylut_arbiter_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int EW = NREQ + 1;

    // Returns {found, index}: first requester with valid set, searching
    // ptr, ptr+1, ... modulo NREQ.
    function automatic logic [PW:0] rr_pick(input logic [PW-1:0] ptr,
                                            input logic [NREQ-1:0] vld);
        logic          found;
        logic [PW-1:0] idx;
        int            c;
        found = 1'b0;
        idx   = '0;
        // Walk offsets from the far end so the nearest hit is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            c = int'(ptr) + k;
            c = (c >= NREQ) ? (c - NREQ) : c;
            if (vld[c]) begin
                found = 1'b1;
                idx   = PW'(c);
            end else begin
                found = found;
                idx   = idx;
            end
        end
        return {found, idx};
    endfunction

    logic [PW-1:0]          rr_ptr_r;
    logic [15:0]            grant_count_r;
    logic [LAT-1:0][EW-1:0] pipe_r;        // [NREQ] = valid, [NREQ-1:0] = tag

    logic [PW:0]            pick_s;
    logic                   grant_any_s;
    logic [PW-1:0]          grant_idx_s;
    logic [NREQ-1:0]        grant_s;
    logic [AW-1:0]          grant_addr_s;
    logic [NREQ-1:0]        rsp_valid_s;
    logic                   busy_s;
    logic [15:0]            grant_count_s;

    // Combinational round-robin grant, suppressed by hold and by reset.
    always_comb begin
        pick_s       = rr_pick(rr_ptr_r, bus.req_valid);
        grant_idx_s  = pick_s[PW-1:0];
        grant_any_s  = 1'b0;
        grant_s      = '0;
        grant_addr_s = '0;
        if (!rst && !bus.hold && pick_s[PW]) begin
            grant_any_s  = 1'b1;
            grant_s      = NREQ'(1) << grant_idx_s;
            grant_addr_s = bus.req_addr[int'(grant_idx_s)*AW +: AW];
        end else begin
            grant_any_s  = 1'b0;
        end
    end

    // Round-robin pointer, accepted-request counter and owner-tag pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_r      <= '0;
            grant_count_r <= 16'd0;
            pipe_r        <= '0;
        end else begin
            if (grant_any_s) begin
                rr_ptr_r      <= (grant_idx_s == PW'(NREQ - 1)) ? '0 : (grant_idx_s + PW'(1));
                grant_count_r <= grant_count_r + 16'd1;
            end else begin
                rr_ptr_r      <= rr_ptr_r;
                grant_count_r <= grant_count_r;
            end
            // The token shifts every cycle, hold or not, so in-flight
            // results always line up with the polylut latency.
            pipe_r[0] <= {grant_any_s, grant_s};
            for (int k = 1; k < LAT; k++) begin
                pipe_r[k] <= pipe_r[k-1];
            end
        end
    end

    // Response and status; forced idle while rst is high because the
    // synchronous reset has not yet cleared the registers in that cycle.
    always_comb begin
        busy_s = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            busy_s = busy_s | pipe_r[k][NREQ];
        end
        if (rst) begin
            busy_s        = 1'b0;
            rsp_valid_s   = '0;
            grant_count_s = 16'd0;
        end else begin
            rsp_valid_s   = pipe_r[LAT-1][NREQ] ? pipe_r[LAT-1][NREQ-1:0] : '0;
            grant_count_s = grant_count_r;
        end
    end

    assign bus.req_ready   = grant_s;
    assign bus.lut_address = grant_addr_s;
    assign bus.rsp_valid   = rsp_valid_s;
    assign bus.rsp_data    = bus.lut_M2;
    assign bus.busy        = busy_s;
    assign bus.grant_count = grant_count_s;
endmodule

// File: doc/polylut_arbiter.md
POLYLUT_ARBITER -- requirements
Module: polylut_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  NREQ, 4, number of requesters sharing one polylut instance
  AW, 64, polylut address width
  OW, 20, polylut result (M2) width
  LAT, 2, polylut address-to-M2 latency in clk cycles (1..8)
REQ-002 Ports SHALL be, one per line:
  clk  input  1  single clock, all logic rising-edge
  rst  input  1  synchronous, active-high reset
  req_valid  input  NREQ  per-requester request valid
  req_addr  input  NREQ*AW  requester i address at bits [i*AW +: AW]
  req_ready  output  NREQ  one-hot grant; request accepted when valid&ready
  hold  input  1  suspends new grants; in-flight results still return
  lut_address  output  AW  address driven to polylut
  lut_M2  input  OW  result from polylut
  rsp_valid  output  NREQ  one-hot, marks owner of rsp_data
  rsp_data  output  OW  returned result
  busy  output  1  any transaction in flight
  grant_count  output  16  total accepted requests, wraps
REQ-003 One clock; reset is synchronous and active-high, ports named clk and rst.

Function
REQ-004 Arbitration SHALL be combinational each cycle: with hold=0, grant the first i with req_valid[i]=1 in order rr_ptr, rr_ptr+1, ... mod NREQ.
REQ-005 req_ready SHALL be one-hot for the granted index, all-zero if no valid request, hold=1, or rst=1.
REQ-006 lut_address SHALL equal the granted requester's req_addr slice in the grant cycle; zero when no grant.
REQ-007 rr_ptr (log2(NREQ) bits) SHALL update to (granted index + 1) mod NREQ on a grant; unchanged otherwise.
REQ-008 Each grant SHALL push {valid=1, one-hot tag} into a LAT-deep shift register; non-grant cycles push {0, 0}; register shifts every cycle regardless of hold.
REQ-009 Grant in cycle t SHALL produce rsp_valid = that grant's one-hot tag and rsp_data = lut_M2 in cycle t+LAT (rsp_valid driven from the shift register output, rsp_data = lut_M2 pass-through).
REQ-010 rsp_valid SHALL be zero in cycles with no matured entry; rsp_data is don't-care then.
REQ-011 No response backpressure: one grant per cycle, one response per cycle max, throughput one per cycle.
REQ-012 busy SHALL be OR of all shift-register valid bits.
REQ-013 grant_count SHALL increment by 1 per accepted request, wrapping 0xFFFF -> 0x0000.
REQ-014 A requester deasserting req_valid before grant SHALL be skipped without penalty; rr_ptr is not advanced.
REQ-015 hold asserted mid-stream: grants stop that same cycle; entries already in flight complete at their scheduled cycles.
REQ-016 Simultaneous request by all NREQ: grants SHALL rotate strictly, each requester granted once per NREQ cycles.

Reset
REQ-017 While rst=1: rr_ptr=0, shift register cleared, req_ready=0, rsp_valid=0, busy=0, grant_count=0, lut_address=0.
REQ-018 Reset mid-operation SHALL discard all in-flight entries; no rsp_valid for grants issued before reset, even though lut_M2 keeps changing.
REQ-019 First grant is possible in the first cycle with rst=0.

Verification (NREQ=4, LAT=2, 10 ns clk, rst held 10 cycles)
REQ-020 Reset: rst=1 for 10 cycles, req_valid=4'b1111 -> req_ready=0, rsp_valid=0, busy=0, grant_count=0 throughout.
REQ-021 Single request: cycle t req_valid=4'b0001, req_addr[63:0]=0x0123456789ABCDEF -> req_ready=4'b0001 and lut_address=0x0123456789ABCDEF at t; rsp_valid=4'b0001, rsp_data=lut_M2 at t+2; grant_count=1.
REQ-022 Full contention: req_valid=4'b1111 for 8 cycles from rr_ptr=0 -> grants 0,1,2,3,0,1,2,3; rsp_valid same sequence delayed 2 cycles; grant_count=8.
REQ-023 Wrap fairness: rr_ptr=3, req_valid=4'b0101 -> grant index 0, rr_ptr becomes 1; next cycle grant index 2.
REQ-024 Hold: grants at t, t+1, hold=1 from t+2 -> no req_ready from t+2; rsp_valid at t+2 and t+3; busy=0 from t+4.
REQ-025 Reset mid-flight: grant at t, rst=1 at t+1 for 1 cycle -> rsp_valid=0 at t+2 and t+3, busy=0 from t+2.
